pemstat_linc_bank: RTL and testbench
====================================

# pemstat_linc_bank

Parametrised bank of NCH statistics counters for the CoreTSE MAC statistics block, replacing per-statistic single-increment counters. Each channel accepts a multi-unit increment per cycle (frame or byte counts), supports wrap-with-carry or saturating mode, and clears on host read when selected. A shared host port with address decode loads and reads counters with one-cycle read latency. Per-channel sticky carry flags feed the statistics interrupt logic.

## Interface
- NCH, 8: number of counter channels, 1..32
- CW, 18: counter width, 1..DW
- IW, 14: increment amount width, 1..CW
- DW, 31: host data width
- AW, 5: host address width; at least clog2(NCH)
- SAT, 0: 0 = wrap and set carry; 1 = saturate at all-ones and set carry
- COR, 1: 1 = clear-on-read enabled; 0 = reads are non-destructive
- DLY, 1: simulation-only non-blocking assignment delay
- reset  in  1  asynchronous reset, active-high; one clock domain only
- clk  in  1  clock; all state updates on its rising edge
- inc_vld  in  NCH  per-channel increment request
- inc_val  in  NCH*IW  per-channel increment amount; channel i is bits [i*IW +: IW]
- wr_en  in  1  host load strobe
- wr_addr  in  AW  host load channel
- wr_data  in  DW  load value; bits [CW-1:0] are used
- rd_en  in  1  host read strobe
- rd_addr  in  AW  host read channel
- rd_data  out  DW  registered read value, zero-extended from CW
- rd_vld  out  1  one-cycle pulse, aligned with rd_data
- carry_clr  in  NCH  per-channel carry clear
- carry  out  NCH  sticky per-channel overflow/saturation flag
- carry_any  out  1  registered OR of carry

## Operation
- Per-channel counter update priority, evaluated each cycle:
  - 1. wr_en with wr_addr == i: load wr_data[CW-1:0]. Any same-cycle increment is dropped.
  - 2. Else, if COR=1, rd_en and rd_addr == i: load inc_vld[i] ? inc_val_i : 0. The increment is not lost.
  - 3. Else, if inc_vld[i]: compute sum = cnt + inc_val_i at CW+1 bits.
    - If sum[CW]=0: cnt <= sum[CW-1:0].
    - If sum[CW]=1 and SAT=0: cnt <= sum[CW-1:0].
    - If sum[CW]=1 and SAT=1: cnt <= all-ones.
  - 4. Else: hold.
- Carry flag priority:
  - carry_clr[i] clears it. Clear wins over a same-cycle set.
  - Otherwise, the flag is set when case 3 is taken with sum[CW]=1.
  - The flag is not set by loads or by the read-clear path.
- Read:
  - rd_data is the counter value *before* the same-cycle update.
  - If a write and a read target the same channel in the same cycle, rd_data returns the old value and the write wins.
  - A read with rd_addr >= NCH returns 0 with rd_vld=1 and has no side effects.
  - A write with wr_addr >= NCH is ignored.
  - When rd_en=0, rd_data holds its last value.
- inc_val = 0 with inc_vld=1 is legal. The counter holds, but a read-clear in the same cycle still clears it.

## Timing
- Reset values:
  - all counters 0
  - carry = 0
  - carry_any = 0
  - rd_data = 0
  - rd_vld = 0
- Reset is asynchronous on assertion. Deassertion is taken synchronously by upstream logic; the block does not synchronise it.
- Counter and carry latency: the new value is visible the cycle after the strobe edge.
- carry_any lags carry by one cycle.
- Read latency: rd_data and rd_vld are valid exactly 1 cycle after the rd_en edge. Back-to-back reads on consecutive cycles are supported, one result per cycle.
- Reset mid-operation: all state clears immediately. A pending read result is discarded and rd_vld is forced to 0.
- There is no backpressure on any port. Every strobe is consumed in its cycle.

## Test plan
- Reset, then NCH=8, CW=18: pulse inc_vld[3] with inc_val=5 for 4 cycles, then read channel 3.
  - Required: rd_data=20 one cycle after rd_en, rd_vld pulses once.
  - Required: a second read returns 0 (COR=1).
- Wrap, SAT=0: load channel 0 with 0x3FFFE, then increment by 3.
  - Required: counter=0x00001.
  - Required: carry[0]=1 next cycle, carry_any=1 the cycle after.
  - Then assert carry_clr[0] together with an overflowing increment: required carry[0]=0.
- Saturate, SAT=1: load 0x3FFF0, then increment by 0x20.
  - Required: counter=0x3FFFF and carry=1.
  - A further increment by 1 keeps 0x3FFFF.
- Simultaneous events on channel 2, holding 100, in one cycle:
  - rd_en + inc_vld (inc_val=7): required rd_data=100, counter=7.
  - rd_en + wr_en (wr_data=55) + inc_vld: required rd_data=100, counter=55.
- Out-of-range and COR=0:
  - rd_addr=9: required rd_data=0, rd_vld=1, no counter changes.
  - wr_addr=9: required no effect.
  - With COR=0, two reads of a counter holding 42 both return 42.
- Assert reset mid-stream, with increments active on all channels and a read in flight:
  - Required: all counters, carry, rd_data and rd_vld are 0 while reset is held.
  - Required: counting resumes from 0 after release.

Source files
------------

// File: rtl/pemstat_linc_bank.sv
// pemstat_linc_bank: bank of NCH statistics counters with multi-unit increments,
// wrap or saturate on overflow, clear-on-read host access and sticky carry flags.
module pemstat_linc_bank #(
    parameter int NCH = 8,
    parameter int CW  = 18,
    parameter int IW  = 14,
    parameter int DW  = 31,
    parameter int AW  = 5,
    parameter bit SAT = 1'b0,
    parameter bit COR = 1'b1,
    parameter int DLY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NCH-1:0]    inc_vld_i,
    input  logic [NCH*IW-1:0] inc_val_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DW-1:0]     rd_data_o,
    output logic              rd_vld_o,
    input  logic [NCH-1:0]    carry_clr_i,
    output logic [NCH-1:0]    carry_o,
    output logic              carry_any_o
);
    if (NCH < 1 || NCH > 32 || CW < 1 || CW > DW || IW < 1 || IW > CW ||
        AW < $clog2(NCH) || DLY < 0) begin : g_bad_params
        $error("pemstat_linc_bank: illegal parameter set");
    end

    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [CW:0]    sum [NCH];
    logic [NCH-1:0] carry_q, carry_d, wr_hit, rd_hit, ovf;
    logic [CW-1:0]  rd_sel;
    logic [DW-1:0]  rd_data_q, rd_data_d;
    logic           rd_vld_q, carry_any_q;
    logic           unused_wr_hi;

    assign unused_wr_hi = ^wr_data_i;

    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        ovf     = '0;
        sum     = '{default: '0};
        cnt_d   = cnt_q;
        carry_d = carry_q;
        rd_sel  = '0;
        for (int k = 0; k < NCH; k++) begin
            sum[k]     = {1'b0, cnt_q[k]} + (CW+1)'(inc_val_i[k*IW +: IW]);
            wr_hit[k]  = wr_en_i && wr_addr_i == AW'(k);
            rd_hit[k]  = COR && rd_en_i && rd_addr_i == AW'(k);
            // only a plain increment may overflow; loads and read-clears never set carry
            ovf[k]     = !wr_hit[k] && !rd_hit[k] && inc_vld_i[k] && sum[k][CW];
            cnt_d[k]   = wr_hit[k]       ? wr_data_i[CW-1:0] :
                         rd_hit[k]       ? (inc_vld_i[k] ? CW'(inc_val_i[k*IW +: IW]) : '0) :
                         !inc_vld_i[k]   ? cnt_q[k] :
                         (ovf[k] && SAT) ? '1 : sum[k][CW-1:0];
            carry_d[k] = !carry_clr_i[k] && (carry_q[k] || ovf[k]);
            rd_sel     = rd_addr_i == AW'(k) ? cnt_q[k] : rd_sel;
        end
        rd_data_d = rd_en_i ? DW'(rd_sel) : rd_data_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
            carry_q     <= '0;
            carry_any_q <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            carry_any_q <= |carry_q;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_en_i;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_vld_o    = rd_vld_q;
    assign carry_o     = carry_q;
    assign carry_any_o = carry_any_q;
endmodule

// File: tb/tb_pemstat_linc_bank.sv
// tb_pemstat_linc_bank: three instances (wrap+COR, saturate+COR, wrap without COR)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_pemstat_linc_bank;
    localparam int NCH = 8;
    localparam int CW  = 18;
    localparam int IW  = 14;
    localparam int DW  = 31;
    localparam int AW  = 5;
    localparam longint MOD = 64'd1 << CW;

    logic              clk, reset;
    logic [NCH-1:0]    inc_vld, carry_clr;
    logic [NCH*IW-1:0] inc_val;
    logic              wr_en, rd_en;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     rd_data [3];
    logic              rd_vld [3];
    logic [NCH-1:0]    carry [3];
    logic              carry_any [3];

    int checks = 0;
    int failures = 0;

    bit             m_sat [3] = '{1'b0, 1'b1, 1'b0};
    bit             m_cor [3] = '{1'b1, 1'b1, 1'b0};
    longint         m_cnt [3][NCH];
    logic [NCH-1:0] m_car [3];
    logic           m_any [3];
    longint         m_rd [3];
    logic           m_vld [3];

    pemstat_linc_bank #(.NCH(NCH), .CW(CW), .IW(IW), .DW(DW), .AW(AW), .SAT(1'b0), .COR(1'b1)) u_wrap (
        .clk_i(clk), .reset_i(reset), .inc_vld_i(inc_vld), .inc_val_i(inc_val),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]), .rd_vld_o(rd_vld[0]),
        .carry_clr_i(carry_clr), .carry_o(carry[0]), .carry_any_o(carry_any[0]));

    pemstat_linc_bank #(.NCH(NCH), .CW(CW), .IW(IW), .DW(DW), .AW(AW), .SAT(1'b1), .COR(1'b1)) u_sat (
        .clk_i(clk), .reset_i(reset), .inc_vld_i(inc_vld), .inc_val_i(inc_val),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]), .rd_vld_o(rd_vld[1]),
        .carry_clr_i(carry_clr), .carry_o(carry[1]), .carry_any_o(carry_any[1]));

    pemstat_linc_bank #(.NCH(NCH), .CW(CW), .IW(IW), .DW(DW), .AW(AW), .SAT(1'b0), .COR(1'b0)) u_nocor (
        .clk_i(clk), .reset_i(reset), .inc_vld_i(inc_vld), .inc_val_i(inc_val),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[2]), .rd_vld_o(rd_vld[2]),
        .carry_clr_i(carry_clr), .carry_o(carry[2]), .carry_any_o(carry_any[2]));

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < NCH; i++) m_cnt[m][i] = 0;
            m_car[m] = '0;
            m_any[m] = 1'b0;
            m_rd[m]  = 0;
            m_vld[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        longint inc, s, n;
        bit ov;
        logic [NCH-1:0] nc;
        for (int m = 0; m < 3; m++) begin
            nc = m_car[m];
            m_any[m] = |m_car[m];
            m_vld[m] = rd_en;
            if (rd_en) m_rd[m] = int'(rd_addr) < NCH ? m_cnt[m][int'(rd_addr)] : 0;
            for (int i = 0; i < NCH; i++) begin
                inc = longint'(inc_val[i*IW +: IW]);
                ov  = 1'b0;
                n   = m_cnt[m][i];
                if (wr_en && int'(wr_addr) == i) n = longint'(wr_data) % MOD;
                else if (m_cor[m] && rd_en && int'(rd_addr) == i) n = inc_vld[i] ? inc : 0;
                else if (inc_vld[i]) begin
                    s  = m_cnt[m][i] + inc;
                    ov = s >= MOD;
                    n  = !ov ? s : m_sat[m] ? MOD - 1 : s - MOD;
                end
                nc[i] = carry_clr[i] ? 1'b0 : (m_car[m][i] | ov);
                m_cnt[m][i] = n;
            end
            m_car[m] = nc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear(); else model_step();
        #1;
    endtask

    task automatic idle();
        inc_vld = '0; inc_val = '0; carry_clr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic set_inc(input int ch, input int v);
        inc_vld[ch] = 1'b1;
        inc_val[ch*IW +: IW] = IW'(v);
    endtask

    task automatic wr(input int ch, input int v);
        wr_en = 1'b1; wr_addr = AW'(ch); wr_data = DW'(v);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input int ch);
        rd_en = 1'b1; rd_addr = AW'(ch);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        model_clear();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) #1; else begin tick(); tick(); end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (rd_data[m] !== '0 || rd_vld[m] !== 1'b0 || carry[m] !== '0 || carry_any[m] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset inst%0d rd_data=%0h rd_vld=%b carry=%b carry_any=%b required all 0",
                             m, rd_data[m], rd_vld[m], carry[m], carry_any[m]);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_count_read();
        set_inc(3, 5);
        repeat (4) tick();
        idle();
        rd(3);
        checks++;
        if (rd_data[0] !== 31'd20 || rd_vld[0] !== 1'b1) begin
            failures++;
            $display("FAIL count_read rd_data=%0d rd_vld=%b required 20/1", rd_data[0], rd_vld[0]);
        end
        tick();
        checks++;
        if (rd_vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL rd_vld_pulse rd_vld=%b required 0", rd_vld[0]);
        end
        rd(3);
        checks++;
        if (rd_data[0] !== 31'd0 || rd_data[2] !== 31'd20) begin
            failures++;
            $display("FAIL clear_on_read cor1=%0d cor0=%0d required 0/20", rd_data[0], rd_data[2]);
        end
    endtask

    task automatic test_wrap();
        wr(0, 'h3FFFE);
        set_inc(0, 3);
        tick();
        idle();
        checks++;
        if (carry[0][0] !== 1'b1 || carry_any[0] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_carry carry0=%b carry_any=%b required 1/0", carry[0][0], carry_any[0]);
        end
        tick();
        checks++;
        if (carry_any[0] !== 1'b1) begin
            failures++;
            $display("FAIL carry_any_lag carry_any=%b required 1", carry_any[0]);
        end
        rd(0);
        checks++;
        if (rd_data[0] !== 31'h00001) begin
            failures++;
            $display("FAIL wrap_value rd_data=%0h required 1", rd_data[0]);
        end
        wr(0, 'h3FFFF);
        set_inc(0, 1);
        carry_clr[0] = 1'b1;
        tick();
        idle();
        checks++;
        if (carry[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL carry_clr_wins carry0=%b required 0", carry[0][0]);
        end
    endtask

    task automatic test_saturate();
        wr(1, 'h3FFF0);
        set_inc(1, 'h20);
        tick();
        idle();
        checks++;
        if (carry[1][1] !== 1'b1) begin
            failures++;
            $display("FAIL sat_carry carry1=%b required 1", carry[1][1]);
        end
        set_inc(1, 1);
        tick();
        idle();
        rd(1);
        checks++;
        if (rd_data[1] !== 31'h3FFFF || rd_data[0] !== 31'h11) begin
            failures++;
            $display("FAIL saturate sat=%0h wrap=%0h required 3ffff/11", rd_data[1], rd_data[0]);
        end
    endtask

    task automatic test_simultaneous();
        wr(2, 100);
        rd_en = 1'b1; rd_addr = 2;
        set_inc(2, 7);
        tick();
        idle();
        checks++;
        if (rd_data[0] !== 31'd100) begin
            failures++;
            $display("FAIL rd_inc_old rd_data=%0d required 100", rd_data[0]);
        end
        rd(2);
        checks++;
        if (rd_data[0] !== 31'd7 || rd_data[2] !== 31'd107) begin
            failures++;
            $display("FAIL rd_inc_new cor1=%0d cor0=%0d required 7/107", rd_data[0], rd_data[2]);
        end
        wr(2, 100);
        rd_en = 1'b1; rd_addr = 2;
        wr_en = 1'b1; wr_addr = 2; wr_data = 55;
        set_inc(2, 7);
        tick();
        idle();
        checks++;
        if (rd_data[0] !== 31'd100) begin
            failures++;
            $display("FAIL rd_wr_old rd_data=%0d required 100", rd_data[0]);
        end
        rd(2);
        checks++;
        if (rd_data[0] !== 31'd55 || rd_data[2] !== 31'd55) begin
            failures++;
            $display("FAIL rd_wr_new cor1=%0d cor0=%0d required 55/55", rd_data[0], rd_data[2]);
        end
    endtask

    task automatic test_out_of_range();
        wr(1, 77);
        wr(9, 123);
        rd(9);
        checks++;
        if (rd_data[0] !== 31'd0 || rd_vld[0] !== 1'b1) begin
            failures++;
            $display("FAIL oor_read rd_data=%0d rd_vld=%b required 0/1", rd_data[0], rd_vld[0]);
        end
        rd(1);
        checks++;
        if (rd_data[0] !== 31'd77) begin
            failures++;
            $display("FAIL oor_side_effect rd_data=%0d required 77", rd_data[0]);
        end
    endtask

    task automatic test_no_cor();
        wr(4, 42);
        rd(4);
        checks++;
        if (rd_data[2] !== 31'd42 || rd_data[0] !== 31'd42) begin
            failures++;
            $display("FAIL no_cor_first cor0=%0d cor1=%0d required 42/42", rd_data[2], rd_data[0]);
        end
        rd(4);
        checks++;
        if (rd_data[2] !== 31'd42 || rd_data[0] !== 31'd0) begin
            failures++;
            $display("FAIL no_cor_second cor0=%0d cor1=%0d required 42/0", rd_data[2], rd_data[0]);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            inc_vld = NCH'($urandom);
            for (int i = 0; i < NCH; i++)
                inc_val[i*IW +: IW] = $urandom_range(0, 1) ? IW'($urandom_range(0, 15)) : IW'($urandom);
            wr_en     = $urandom_range(0, 9) == 0;
            wr_addr   = AW'($urandom_range(0, 11));
            wr_data   = $urandom_range(0, 1) ? DW'(32'h3FF00 + $urandom_range(0, 255)) : DW'($urandom);
            rd_en     = $urandom_range(0, 2) == 0;
            rd_addr   = AW'($urandom_range(0, 9));
            carry_clr = $urandom_range(0, 7) == 0 ? NCH'($urandom) : '0;
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (rd_vld[m] !== m_vld[m] || rd_data[m] !== DW'(m_rd[m]) ||
                    carry[m] !== m_car[m] || carry_any[m] !== m_any[m]) begin
                    failures++;
                    $display("FAIL random cyc%0d inst%0d got vld=%b data=%0h carry=%b any=%b required vld=%b data=%0h carry=%b any=%b",
                             cyc, m, rd_vld[m], rd_data[m], carry[m], carry_any[m],
                             m_vld[m], DW'(m_rd[m]), m_car[m], m_any[m]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        inc_vld = '1;
        for (int i = 0; i < NCH; i++) inc_val[i*IW +: IW] = IW'($urandom);
        rd_en = 1'b1; rd_addr = 2;
        tick();
        tick();
        reset = 1'b1;
        model_clear();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) #1; else begin tick(); tick(); end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (rd_data[m] !== '0 || rd_vld[m] !== 1'b0 || carry[m] !== '0 || carry_any[m] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid inst%0d rd_data=%0h rd_vld=%b carry=%b carry_any=%b required all 0",
                             m, rd_data[m], rd_vld[m], carry[m], carry_any[m]);
                end
            end
        end
        idle();
        reset = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            rd(ch);
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (rd_data[m] !== '0 || rd_vld[m] !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_cnt inst%0d ch%0d rd_data=%0h rd_vld=%b required 0/1", m, ch, rd_data[m], rd_vld[m]);
                end
            end
        end
        set_inc(5, 3);
        repeat (2) tick();
        idle();
        rd(5);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (rd_data[m] !== 31'd6) begin
                failures++;
                $display("FAIL resume inst%0d rd_data=%0d required 6", m, rd_data[m]);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        idle();
        test_reset();
        test_count_read();
        test_wrap();
        test_saturate();
        test_simultaneous();
        test_out_of_range();
        test_no_cor();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
